// File: rtl/uart_txq_pkg.sv
// -----------------------------------------------------------------------------
// uart_txq_pkg
// Shared definitions for the UART transmit byte queue:
//   - BYTE_W      : width of one queued character
//   - txq_state_e : launch FSM states (IDLE, START, WAIT_BUSY, WAIT_DONE)
// -----------------------------------------------------------------------------
package uart_txq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,  // waiting for a queued byte and an idle transmitter
      START     = 2'd1,  // one-cycle start pulse to the transmitter
      WAIT_BUSY = 2'd2,  // waiting for the transmitter to report busy
      WAIT_DONE = 2'd3   // frame in progress, waiting for idle again
   } txq_state_e;

endpackage : uart_txq_pkg

// File: rtl/uart_txq_mem.sv
// -----------------------------------------------------------------------------
// uart_txq_mem
// DEPTH x WIDTH register-file storage for the transmit queue.
// One synchronous write port, one asynchronous (combinational) read port.
// The data array carries no reset; only the pointers in the parent decide
// which entries are meaningful.
//
// Ports:
//   clk    in   storage clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  data at raddr (combinational)
// -----------------------------------------------------------------------------
module uart_txq_mem
   import uart_txq_pkg::*;
#(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = BYTE_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage is deliberately left out of reset; an entry is only read
   // after it has been written, so resetting it would just cost reset fan-out.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values, independent of statement or process order.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : uart_txq_mem

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
// Byte FIFO between the CPU write strobe and the UART transmitter. Bytes are
// accepted on wr_en, buffered, and launched one at a time over the
// xmitH / xmit_dataH / xmit_doneH handshake.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   BUSY_TIMEOUT cycles spent in WAIT_BUSY before the start pulse is re-issued
//
// Ports:
//   sys_clk     in   clock (same net as the transmitter)
//   sys_rst     in   asynchronous, active-high reset
//   wr_en       in   one-cycle write strobe
//   wr_data     in   byte to enqueue
//   full        out  registered, count == DEPTH
//   empty       out  registered, count == 0
//   count       out  current occupancy
//   xmitH       out  one-cycle start pulse to the transmitter
//   xmit_dataH  out  byte presented to the transmitter
//   xmit_doneH  in   1 = transmitter idle, 0 = frame in progress
//   ovf         out  sticky overflow flag          (UART_TXQ_OVF_EN only)
//   ovf_clr     in   clears ovf, a new set wins    (UART_TXQ_OVF_EN only)
//
// Configuration macro: UART_TXQ_OVF_EN adds the overflow flag; without it a
// write into a full queue is dropped silently.
// -----------------------------------------------------------------------------
module uart_tx_queue
   import uart_txq_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       wr_en,
   input  logic [BYTE_W-1:0]          wr_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       xmitH,
   output logic [BYTE_W-1:0]          xmit_dataH,
   input  logic                       xmit_doneH
`ifdef UART_TXQ_OVF_EN
   ,
   output logic                       ovf,
   input  logic                       ovf_clr
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   // ---------------------------------------------------------------------------
   // Queue bookkeeping
   // ---------------------------------------------------------------------------
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ready_q, ready_d;

   logic              wr_ok;
   logic              pop;
   logic [BYTE_W-1:0] rd_data;

   // FSM registers
   txq_state_e        state_q;
   logic              xmit_q;
   logic [BYTE_W-1:0] xmit_data_q;
   logic [TW-1:0]     tmo_cnt_q;
   logic [TW-1:0]     tmo_inc;

   // full is the pre-cycle value, so a write into a full queue is dropped even
   // when the FSM pops in the same cycle.
   assign wr_ok = wr_en && !full_q;

   // ready_q is the queue's non-empty status delayed by one cycle: a byte
   // landing in an empty queue is launched only after it has been visible for
   // a full cycle. While bytes are waiting back-to-back it stays high, so the
   // done-to-next-start gap is unaffected.
   assign pop = (state_q == IDLE) && !empty_q && ready_q && xmit_doneH;

   assign tmo_inc = tmo_cnt_q + TW'(1);

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      // wr_ok needs count < DEPTH and pop needs count > 0, so count never wraps.
      case ({wr_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
      ready_d = !empty_q;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ready_q  <= ready_d;
      end
   end

   uart_txq_mem #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_mem (
      .clk   (sys_clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   // ---------------------------------------------------------------------------
   // Launch FSM. xmitH is registered and high exactly while in START;
   // xmit_dataH is loaded only on a pop, so it is stable through
   // WAIT_BUSY / WAIT_DONE and across timeout re-pulses.
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         xmit_q      <= 1'b0;
         xmit_data_q <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  xmit_data_q <= rd_data;
                  xmit_q      <= 1'b1;
                  state_q     <= START;
               end
            end

            START: begin
               xmit_q    <= 1'b0;
               tmo_cnt_q <= '0;
               state_q   <= WAIT_BUSY;
            end

            WAIT_BUSY: begin
               if (!xmit_doneH) begin
                  state_q <= WAIT_DONE;
               end else begin
                  // Transmitter missed the pulse: after BUSY_TIMEOUT idle
                  // cycles, pulse again with the same byte.
                  tmo_cnt_q <= tmo_inc;
                  if (tmo_inc == TW'(BUSY_TIMEOUT)) begin
                     xmit_q  <= 1'b1;
                     state_q <= START;
                  end
               end
            end

            WAIT_DONE: begin
               if (xmit_doneH) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               xmit_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign full       = full_q;
   assign empty      = empty_q;
   assign count      = count_q;
   assign xmitH      = xmit_q;
   assign xmit_dataH = xmit_data_q;

`ifdef UART_TXQ_OVF_EN
   // ---------------------------------------------------------------------------
   // Sticky overflow flag: set the cycle after a dropped write; a set in the
   // same cycle as ovf_clr takes priority.
   // ---------------------------------------------------------------------------
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (wr_en && full_q) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule : uart_tx_queue

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
// Self-checking bench for uart_tx_queue (DEPTH=8, BUSY_TIMEOUT=15).
// Inputs are driven on the falling edge, outputs sampled on the falling edge
// after each rising edge. The transmitter is modelled by driving xmit_doneH
// directly from the stimulus. Cycle numbering: cycle 0 is the cycle in which
// wr_en is held high; cycle N is the cycle after the N-th rising edge.
// Overflow checks are compiled in when UART_TXQ_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

   localparam int DEPTH        = 8;
   localparam int BUSY_TIMEOUT = 15;
   localparam int CW           = $clog2(DEPTH + 1);

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          xmitH;
   logic [7:0]    xmit_dataH;
   logic          xmit_doneH;
`ifdef UART_TXQ_OVF_EN
   logic          ovf;
   logic          ovf_clr;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 sys_clk = ~sys_clk;

   uart_tx_queue #(
      .DEPTH        (DEPTH),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .xmitH      (xmitH),
      .xmit_dataH (xmit_dataH),
      .xmit_doneH (xmit_doneH)
`ifdef UART_TXQ_OVF_EN
      ,
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
`endif
   );

   typedef struct {
      logic       wr_en;
      logic [7:0] data;
      int         exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   // Wait (bounded) for a start pulse, then check the presented byte.
   task automatic wait_pulse(input string name, input logic [7:0] exp_data, input int budget);
      int k;
      k = 0;
      while (xmitH !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check({name, " pulse seen"}, xmitH, 1'b1);
      check({name, " data"}, xmit_dataH, exp_data);
   endtask

   // Transmitter model: busy for n cycles, then idle again.
   task automatic frame(input int n);
      xmit_doneH = 1'b0;
      repeat (n) tick();
      xmit_doneH = 1'b1;
   endtask

   // Count start pulses over n cycles.
   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (xmitH === 1'b1) pulses++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      int data_moved;

      // Fill table: transmitter held busy, so nothing is popped.
      vecs[0] = '{1'b1, 8'h01, 1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'h02, 2, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h03, 3, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h04, 4, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h05, 5, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 8'h06, 6, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h07, 7, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h08, 8, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 8'h09, 8, 1'b1, 1'b0, 1'b1};  // dropped
      vecs[9] = '{1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b1};

      sys_rst    = 1'b1;
      wr_en      = 1'b0;
      wr_data    = 8'h00;
      xmit_doneH = 1'b1;
`ifdef UART_TXQ_OVF_EN
      ovf_clr    = 1'b0;
`endif
      @(negedge sys_clk);
      tick();
      tick();
      sys_rst = 1'b0;

      // ---- Reset state after 10 idle cycles --------------------------------
      repeat (10) tick();
      check("reset empty", empty, 1'b1);
      check("reset full", full, 1'b0);
      check("reset count", count, 0);
      check("reset xmitH", xmitH, 1'b0);
      check("reset xmit_dataH", xmit_dataH, 8'h00);
`ifdef UART_TXQ_OVF_EN
      check("reset ovf", ovf, 1'b0);
`endif

      // ---- First write latency: A5 --------------------------------------
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      tick();                                   // cycle 1
      wr_en = 1'b0;
      check("wr1 c1 empty", empty, 1'b0);
      check("wr1 c1 count", count, 1);
      check("wr1 c1 xmitH", xmitH, 1'b0);
      tick();                                   // cycle 2
      check("wr1 c2 xmitH", xmitH, 1'b0);
      tick();                                   // cycle 3
      check("wr1 c3 xmitH", xmitH, 1'b1);
      check("wr1 c3 data", xmit_dataH, 8'hA5);
      check("wr1 c3 count", count, 0);

      // Transmitter busy 20 cycles; queue 3C while the frame runs.
      xmit_doneH = 1'b0;
      pulses     = 0;
      data_moved = 0;
      for (int i = 0; i < 20; i++) begin
         wr_en   = (i == 5);
         wr_data = 8'h3C;
         tick();
         if (i == 0) check("wr1 pulse one cycle", xmitH, 1'b0);
         if (xmitH === 1'b1) pulses++;
         if (xmit_dataH !== 8'hA5) data_moved++;
      end
      wr_en = 1'b0;
      check("busy no pulse", pulses, 0);
      check("busy data stable", data_moved, 0);
      check("busy count", count, 1);
      xmit_doneH = 1'b1;                        // rise, cycle t
      tick();                                   // t+1: back in IDLE
      check("gap t+1 xmitH", xmitH, 1'b0);
      tick();                                   // t+2: START
      check("gap t+2 xmitH", xmitH, 1'b1);
      check("gap t+2 data", xmit_dataH, 8'h3C);
      frame(5);
      repeat (3) tick();
      check("drained empty", empty, 1'b1);

      // ---- Fill past DEPTH with the transmitter busy (table) ---------------
      xmit_doneH = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wr_en   = vecs[i].wr_en;
         wr_data = vecs[i].data;
         tick();
         check($sformatf("fill[%0d] count", i), count, vecs[i].exp_count);
         check($sformatf("fill[%0d] full", i), full, vecs[i].exp_full);
         check($sformatf("fill[%0d] empty", i), empty, vecs[i].exp_empty);
         check($sformatf("fill[%0d] xmitH", i), xmitH, 1'b0);
`ifdef UART_TXQ_OVF_EN
         check($sformatf("fill[%0d] ovf", i), ovf, vecs[i].exp_ovf);
`endif
      end
      wr_en = 1'b0;

`ifdef UART_TXQ_OVF_EN
      // Clear coinciding with a dropped write: the set wins.
      ovf_clr = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hDD;
      tick();
      wr_en = 1'b0;
      check("ovf set wins", ovf, 1'b1);
      tick();
      ovf_clr = 1'b0;
      check("ovf cleared", ovf, 1'b0);
      check("ovf clr count", count, 8);
`endif

      // ---- Write while full in the same cycle as an IDLE pop --------------
      xmit_doneH = 1'b1;
      wr_en      = 1'b1;
      wr_data    = 8'hEE;
      tick();
      wr_en = 1'b0;
      check("full+pop count", count, 7);
      check("full+pop full", full, 1'b0);
      check("full+pop xmitH", xmitH, 1'b1);
      check("full+pop data", xmit_dataH, 8'h01);
`ifdef UART_TXQ_OVF_EN
      check("full+pop ovf", ovf, 1'b1);
`endif
      frame(4);

      // Remaining bytes leave in order; EE and 09 never appear.
      for (int b = 2; b <= 8; b++) begin
         wait_pulse($sformatf("order %0d", b), 8'(b), 10);
         frame(4);
      end
      count_pulses(20, pulses);
      check("order no extra", pulses, 0);
      check("order empty", empty, 1'b1);
      check("order count", count, 0);

      // ---- Transmitter never goes busy: timeout re-pulse ------------------
      wr_en   = 1'b1;
      wr_data = 8'h5A;
      tick();
      wr_data = 8'h77;
      tick();
      wr_en = 1'b0;
      wait_pulse("tmo first", 8'h5A, 10);
      for (int rep = 0; rep < 2; rep++) begin
         pulses     = 0;
         data_moved = 0;
         for (int k = 1; k <= BUSY_TIMEOUT; k++) begin
            tick();
            if (xmitH === 1'b1) pulses++;
            if (xmit_dataH !== 8'h5A) data_moved++;
         end
         check($sformatf("tmo[%0d] quiet", rep), pulses, 0);
         check($sformatf("tmo[%0d] data stable", rep), data_moved, 0);
         tick();
         check($sformatf("tmo[%0d] re-pulse", rep), xmitH, 1'b1);
         check($sformatf("tmo[%0d] data", rep), xmit_dataH, 8'h5A);
         check($sformatf("tmo[%0d] count", rep), count, 1);
      end
      frame(4);
      wait_pulse("tmo next", 8'h77, 10);

      // ---- Reset in WAIT_DONE with 3 bytes queued -------------------------
      xmit_doneH = 1'b0;
      wr_en      = 1'b1;
      wr_data    = 8'h11;
      tick();
      wr_data = 8'h22;
      tick();
      wr_data = 8'h33;
      tick();
      wr_en = 1'b0;
      tick();
      check("pre-rst count", count, 3);
      #2 sys_rst = 1'b1;
      #1;
      check("rst count", count, 0);
      check("rst empty", empty, 1'b1);
      check("rst xmitH", xmitH, 1'b0);
      check("rst data", xmit_dataH, 8'h00);
      @(negedge sys_clk);
      tick();
      sys_rst    = 1'b0;
      xmit_doneH = 1'b1;
      count_pulses(30, pulses);
      check("post-rst no pulse", pulses, 0);
      check("post-rst empty", empty, 1'b1);
      wr_en   = 1'b1;
      wr_data = 8'h42;
      tick();
      wr_en = 1'b0;
      wait_pulse("post-rst write", 8'h42, 10);
      frame(4);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_tx_queue
